// File: rtl/fetch_unit_pkg.sv
// Shared types and ROM geometry for the fetch unit.
package fetch_unit_pkg;
  typedef enum logic [1:0] {FETCH, FULL, END} fetch_state_t;

  localparam logic [63:0] ROM_LAST_PC = 64'hFC;
  localparam int          ROM_WORDS   = 64;
  localparam logic [63:0] ROM_END_PC  = 64'(ROM_WORDS * 4);

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'h3;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: ROM port, redirect input, instruction stream and perf counters.
interface fetch_unit_if #(parameter int N = 32);
  logic [5:0]   imem_addr;
  logic [N-1:0] imem_q;
  logic         redirect_valid;
  logic [63:0]  redirect_pc;
  logic         instr_valid;
  logic [N-1:0] instr;
  logic [63:0]  instr_pc;
  logic         instr_ready;
  logic [31:0]  perf_fetched;
  logic [31:0]  perf_stall;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc, perf_fetched, perf_stall,
    input  imem_q, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc, perf_fetched, perf_stall,
    output imem_q, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit_queue.sv
// Prefetch FIFO of {instr, pc} entries; flush clears pointers, reset also zeroes storage.
module fetch_queue #(
  parameter int W     = 96,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher feeding a prefetch queue from a 64-word ROM.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int          N        = 32,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   redir_pc;
  logic [CW-1:0] count;
  logic [N+63:0] head;
  logic          full, valid, push, pop;

  assign full  = (count == DEPTH_C);
  assign valid = (count != '0);
  assign pop   = valid && bus.instr_ready && !bus.redirect_valid;
  assign push  = (state_q != END) && !bus.redirect_valid && (!full || pop);

  assign redir_pc = align_pc(bus.redirect_pc);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      // Targets past the ROM park in END so nothing beyond the last word is fetched.
      fetch_pc_d = redir_pc;
      state_d    = (redir_pc >= ROM_END_PC) ? END : FETCH;
    end else begin
      if (push) fetch_pc_d = fetch_pc_q + 64'd4;
      case (state_q)
        FETCH:   if (push && !pop && count == DEPTH_C - 1'b1) state_d = FULL;
        FULL:    if (pop) state_d = FETCH;
        default: state_d = state_q;
      endcase
      if (push && fetch_pc_q == ROM_LAST_PC) state_d = END;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue #(.W(N + 64), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .push_data ({bus.imem_q, fetch_pc_q}),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_addr   = fetch_pc_q[7:2];
  assign bus.instr_valid = valid;
  assign bus.instr       = head[N+63:64];
  assign bus.instr_pc    = head[63:0];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (push && perf_fetched_q != 32'hFFFF_FFFF) perf_fetched_d = perf_fetched_q + 32'd1;
    if (valid && !bus.instr_ready && perf_stall_q != 32'hFFFF_FFFF)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stall   = perf_stall_q;
`else
  assign bus.perf_fetched = 32'd0;
  assign bus.perf_stall   = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, latency, backpressure, redirects, END and perf.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  fetch_unit_if #(.N(32)) bus ();

  fetch_unit #(.N(32), .DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [5:0] a);
    if (a == 6'd0) return 32'hf8000001;
    if (a == 6'd1) return 32'hf8008002;
    return 32'h1000_0000 + 32'(a);
  endfunction

  assign bus.imem_q = rom_word(bus.imem_addr);

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  function automatic logic [63:0] pexp(input logic [63:0] v);
    return PERF ? v : 64'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc);
    chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd1);
    chk({tag, "_pc"}, bus.instr_pc, pc);
    chk({tag, "_instr"}, 64'(bus.instr), 64'(rom_word(pc[7:2])));
  endtask

  initial begin
    reset = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;

    // reset state, then two-word fetch with consumer ready
    step(); step();
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'd0);
    chk("rst_pc", bus.instr_pc, 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(FETCH));
    chk("rst_pf", 64'(bus.perf_fetched), 64'd0);
    chk("rst_ps", 64'(bus.perf_stall), 64'd0);
    reset = 1'b0;
    step();
    chk("c1_instr", 64'(bus.instr), 64'hf8000001);
    chk("c1_pc", bus.instr_pc, 64'h0);
    step();
    chk("c2_instr", 64'(bus.instr), 64'hf8008002);
    chk("c2_pc", bus.instr_pc, 64'h4);

    // backpressure from reset: queue fills, head held, then drains in order
    reset = 1'b1;
    bus.instr_ready = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 4) chk("fill_cnt4", 64'(dut.u_queue.count), 64'd4);
    end
    chk("full_cnt", 64'(dut.u_queue.count), 64'd4);
    chk("full_state", 64'(dut.state_q), 64'(FULL));
    chk("full_addr", 64'(bus.imem_addr), 64'd4);
    chk_head("hold0", 64'h0);
    chk("stall_ps", 64'(bus.perf_stall), pexp(64'd10));
    chk("stall_pf", 64'(bus.perf_fetched), pexp(64'd4));
    bus.instr_ready = 1'b1;
    step(); chk_head("drain4", 64'h4);
    chk("drain_state", 64'(dut.state_q), 64'(FETCH));
    step(); chk_head("drain8", 64'h8);
    step(); chk_head("drain12", 64'hC);
    step(); chk_head("drain16", 64'h10);
    step(); chk_head("drain20", 64'h14);
    chk("acc_ps", 64'(bus.perf_stall), pexp(64'd10));
    chk("acc_pf", 64'(bus.perf_fetched), pexp(64'd9));

    // redirect with ready high: no pop or push that cycle, target realigned
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h26;
    step();
    chk("redir_valid", 64'(bus.instr_valid), 64'd0);
    chk("redir_cnt", 64'(dut.u_queue.count), 64'd0);
    chk("redir_addr", 64'(bus.imem_addr), 64'd9);
    chk("redir_pf", 64'(bus.perf_fetched), pexp(64'd9));
    bus.redirect_valid = 1'b0;
    step(); chk_head("redir_head", 64'h24);

    // run off the end of the ROM
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hF8;
    step();
    chk("endr_addr", 64'(bus.imem_addr), 64'd62);
    bus.redirect_valid = 1'b0;
    step(); chk_head("end_f8", 64'hF8);
    step(); chk_head("end_fc", 64'hFC);
    chk("end_state", 64'(dut.state_q), 64'(END));
    step(); chk("end_drain", 64'(bus.instr_valid), 64'd0);
    step(); chk("end_idle", 64'(bus.instr_valid), 64'd0);

    // redirect beyond the ROM fetches nothing
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h100;
    step();
    chk("oob_state", 64'(dut.state_q), 64'(END));
    chk("oob_valid0", 64'(bus.instr_valid), 64'd0);
    bus.redirect_valid = 1'b0;
    step(); step();
    chk("oob_valid1", 64'(bus.instr_valid), 64'd0);
    chk("oob_cnt", 64'(dut.u_queue.count), 64'd0);

    // reset dominates a redirect while the queue is full
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0;
    bus.instr_ready    = 1'b0;
    step();
    chk("r0_state", 64'(dut.state_q), 64'(FETCH));
    bus.redirect_valid = 1'b0;
    step(); step(); step(); step();
    chk("pre_rst_cnt", 64'(dut.u_queue.count), 64'd4);
    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h40;
    step();
    chk("mrst_cnt", 64'(dut.u_queue.count), 64'd0);
    chk("mrst_valid", 64'(bus.instr_valid), 64'd0);
    chk("mrst_instr", 64'(bus.instr), 64'd0);
    chk("mrst_pc", bus.instr_pc, 64'd0);
    chk("mrst_fpc", dut.fetch_pc_q, 64'h0);
    chk("mrst_state", 64'(dut.state_q), 64'(FETCH));
    chk("mrst_pf", 64'(bus.perf_fetched), 64'd0);
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    step(); chk_head("post0", 64'h0);
    step(); chk_head("post4", 64'h4);
    chk("post_pf", 64'(bus.perf_fetched), pexp(64'd2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
